// File: rtl/dpram_port_arbiter_if.sv
// Requester and RAM port-A signals for the two-requester arbiter.
// The slave side is the arbiter; the master side is the surrounding system.
interface dpram_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wren;
    logic              mem_rden;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  req0, req1, we0, we1,
        input  addr0, addr1, wdata0, wdata1,
        input  mem_q,
        output ack0, ack1, rvalid0, rvalid1,
        output rdata,
        output mem_addr, mem_wdata, mem_wren, mem_rden
    );

    modport master (
        output req0, req1, we0, we1,
        output addr0, addr1, wdata0, wdata1,
        output mem_q,
        input  ack0, ack1, rvalid0, rvalid1,
        input  rdata,
        input  mem_addr, mem_wdata, mem_wren, mem_rden
    );
endinterface

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter with burst allowance sharing RAM port A
// between two requesters; fixed two-cycle read-data return.
module dpram_port_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input logic           clock,
    input logic           reset_n,
    dpram_port_arbiter_if.slave bus
);

    localparam int CW = $clog2(MAX_BURST + 1);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t MAXC = cnt_t'(MAX_BURST);

    logic owner;
    cnt_t burst_cnt;
    logic sat;
    logic sel;
    logic hs;
    logic sel_we;
    logic rd_v;
    logic rd_id;

    // sel: 0 = requester 0, 1 = requester 1
    always_comb begin
        sat      = (burst_cnt >= MAXC);
        sel      = bus.req1;
        if (bus.req0 && bus.req1) begin
            sel = sat ? ~owner : owner;
        end
        hs       = reset_n & (bus.req0 | bus.req1);
        bus.ack0 = hs & ~sel;
        bus.ack1 = hs & sel;
        sel_we   = sel ? bus.we1 : bus.we0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner     <= 1'b0;
            burst_cnt <= '0;
        end else if (hs) begin
            if (sel == owner) begin
                if (!sat) begin
                    burst_cnt <= burst_cnt + cnt_t'(1);
                end
            end else begin
                owner     <= sel;
                burst_cnt <= cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wren  <= 1'b0;
            bus.mem_rden  <= 1'b0;
        end else begin
            bus.mem_wren <= hs & sel_we;
            bus.mem_rden <= hs & ~sel_we;
            if (hs) begin
                bus.mem_addr <= sel ? bus.addr1 : bus.addr0;
            end
            if (hs && sel_we) begin
                bus.mem_wdata <= sel ? bus.wdata1 : bus.wdata0;
            end
        end
    end

    // Stage 1 tracks the issued read, stage 2 lines up with mem_q
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_v        <= 1'b0;
            rd_id       <= 1'b0;
            bus.rvalid0 <= 1'b0;
            bus.rvalid1 <= 1'b0;
        end else begin
            rd_v        <= hs & ~sel_we;
            rd_id       <= sel;
            bus.rvalid0 <= rd_v & ~rd_id;
            bus.rvalid1 <= rd_v & rd_id;
        end
    end

    assign bus.rdata = bus.mem_q;

endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
- Shares one port (port A) of the team's true dual-port block RAM between two requesters, e.g. host-bus engine (requester 0) and video/DMA fetch (requester 1).
- Uses per-cycle round-robin arbitration with a configurable burst allowance.
- Issues registered write/read strobes to the RAM port and returns read data with a fixed-latency valid pulse.
- Port B of the RAM stays outside this block.

Parameters:
- ADDR_W, 8, address width; matches RAM widthad_a.
- DATA_W, 8, data width; matches RAM width_a.
- MAX_BURST, 4, consecutive grants the current owner may take while the other requester waits (>=1; 1 = strict alternation).

Ports:
- clock  in  1  single clock; RAM port A runs on the same clock.
- reset_n  in  1  asynchronous active-low reset.
- req0 / req1  in  1  request valid, requester 0 / 1.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_W  request address.
- wdata0 / wdata1  in  DATA_W  write data.
- ack0 / ack1  out  1  combinational grant; a transfer occurs on the rising edge where reqX && ackX.
- rvalid0 / rvalid1  out  1  registered one-cycle read-data-valid pulse.
- rdata  out  DATA_W  read data, = mem_q; meaningful only while rvalid0 or rvalid1 is high.
- mem_addr  out  ADDR_W  registered; to RAM address_a.
- mem_wdata  out  DATA_W  registered; to RAM data_a.
- mem_wren  out  1  registered; to RAM wren_a.
- mem_rden  out  1  registered; to RAM rden_a.
- mem_q  in  DATA_W  from RAM q_a.

Behaviour:
- Reset (async assert, sync release) clears:
  - outputs: mem_addr, mem_wdata, mem_wren, mem_rden, rvalid0, rvalid1;
  - state: owner (=0), burst_cnt (=0), and the two-stage read pipeline.
  - ack0/ack1 are forced low while reset_n=0.
  - In-flight reads are discarded; no rvalid appears after reset release for pre-reset requests.
- Handshake:
  - Requester holds reqX, weX, addrX and wdataX stable until it sees ackX high at a rising edge.
  - It may present the next request in the following cycle, or keep req high for back-to-back accesses.
  - ack is never high without req.
- Grant decision, combinational from req0, req1, owner and burst_cnt:
  - Only one req high: grant it.
  - Both high, burst_cnt < MAX_BURST: grant owner.
  - Both high, burst_cnt >= MAX_BURST: grant the other requester.
  - Neither high: no grant.
- Owner and burst counter update on a handshake edge:
  - Granted requester == owner: burst_cnt <= burst_cnt+1, saturating at MAX_BURST.
  - Otherwise: owner <= granted, burst_cnt <= 1.
  - No handshake: owner and burst_cnt hold.
- Issue, edge E with a handshake:
  - mem_addr <= addrX; mem_wren <= weX; mem_rden <= !weX.
  - mem_wdata <= wdataX on writes; holds otherwise.
- Issue, edge E without a handshake: mem_wren, mem_rden <= 0; mem_addr and mem_wdata hold.
- Read latency:
  - RAM captures the read at edge E+1.
  - rvalidX is high for exactly the cycle after edge E+2-1, i.e. asserted by edge E+1 with mem_q valid in that cycle. Handshake at E ⇒ rdata valid two cycles after the cycle containing E's request.
  - Pipeline carries the requester ID so rvalid routes to the correct requester.
- Writes produce no rvalid.
- Throughput: one access per clock, sustained; back-to-back reads from alternating requesters give alternating rvalid pulses in order.
- Ordering: same-requester write then read to the same address on consecutive edges returns the new data (RAM port is sequential).
- Simultaneous new request and rvalid pulse on the same requester are independent.

Test Plan:
- Reset mid-read: handshake a read, pull reset_n low before rvalid → rvalid0/1 never pulse; all mem_* outputs = 0 during reset.
- Single requester: write 0x5A to addr 0x10 via requester 0, then read 0x10 → ack0 on each edge, mem_wren one cycle, rvalid0 with rdata=0x5A exactly 2 cycles after the read handshake.
- Contention, MAX_BURST=4: both hold req continuously from reset → grant sequence 0,0,0,0,1,1,1,1,0,…; no cycle without a grant.
- MAX_BURST=1: both requesting → strict alternation 0,1,0,1; reads return to the correct requester with the correct data.
- Idle gap: requester 1 alone issues 3 reads, then requester 0 alone → requester 0 is granted immediately; burst_cnt = 1, owner = 0.
- Write/read collision: requester 1 writes 0xC3 to addr 0x7F, then reads 0x7F next cycle → rvalid1 with rdata=0xC3.
